// File: rtl/seq_div_8x4_if.sv
// Operand/result handshake bundle for the sequential 8x4 divider.
// The master side drives operands and consumes results; the slave side is the divider.
interface seq_div_8x4_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_8x4.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Divide-by-zero bypasses the iteration and reports all-ones quotient with the low dividend bits.
module seq_div_8x4 #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_div_8x4_if.slave  bus_io
);
    localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   q_q, q_d;
    logic [VW-1:0]   rem_q, rem_d;
    logic [VW-1:0]   dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dbz_q, dbz_d;
    logic            in_ready_q, in_ready_d;

    // Shifted partial remainder and trial subtraction; diff MSB is the borrow.
    logic [VW:0]     rs;
    logic [VW+1:0]   diff;
    logic            borrow;
    logic            unused_diff_msb;

    assign rs              = {rem_q, q_q[DW-1]};
    assign diff            = {1'b0, rs} - {2'b00, dvs_q};
    assign borrow          = diff[VW+1];
    // After a successful subtraction the result is below the divisor, so bit VW is always 0.
    assign unused_diff_msb = diff[VW];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid && in_ready_q) begin
                    q_d   = bus_io.dividend;
                    dvs_d = bus_io.divisor;
                    rem_d = '0;
                    cnt_d = CntW'(DW - 1);
                    if (bus_io.divisor == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        rem_d   = bus_io.dividend[VW-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StBusy;
                        dbz_d   = 1'b0;
                    end
                end
            end
            StBusy: begin
                q_d   = {q_q[DW-2:0], ~borrow};
                rem_d = borrow ? rs[VW-1:0] : diff[VW-1:0];
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so in_ready stays low through reset and rises on the first edge after it.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            q_q        <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            dbz_q      <= dbz_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus_io.in_ready    = in_ready_q;
    assign bus_io.out_valid   = (state_q == StDone);
    assign bus_io.quotient    = q_q;
    assign bus_io.remainder   = rem_q;
    assign bus_io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_8x4.sv
// Directed and exhaustive self-checking bench for seq_div_8x4.
// Expected results come from hand constants and an integer divide/modulo reference.
module tb_seq_div_8x4;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   accept_cyc;
    int   first_acc;
    logic [7:0] last_q;
    logic [3:0] last_r;
    logic       last_z;

    seq_div_8x4_if #(.DW(8), .VW(4)) bus ();

    seq_div_8x4 #(.DW(8), .VW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: optional idle gap, accept, latency check, optional stall, handshake.
    task automatic xact(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input int pre, input int stall);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        logic [7:0] hq;
        logic [3:0] hr;
        int         lat;
        int         guard;
        bit         rdy_bad;
        bit         hold_bad;
        if (b == 4'd0) begin
            eq = 8'hFF;
            er = a[3:0];
            ez = 1'b1;
        end else begin
            eq = a / {4'd0, b};
            er = 4'(a % {4'd0, b});
            ez = 1'b0;
        end
        repeat (pre) tick();
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, ":ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        lat     = 0;
        rdy_bad = 1'b0;
        do begin
            tick();
            lat++;
            if (bus.in_ready) rdy_bad = 1'b1;
        end while (!bus.out_valid && lat < 20);
        chk({tag, ":latency"}, 32'(lat), ez ? 32'd1 : 32'd8);
        chk({tag, ":busy_ready"}, 32'(rdy_bad), 32'd0);
        hq       = bus.quotient;
        hr       = bus.remainder;
        hold_bad = 1'b0;
        repeat (stall) begin
            tick();
            if (!bus.out_valid || bus.in_ready || bus.quotient !== hq || bus.remainder !== hr
                || bus.div_by_zero !== ez) hold_bad = 1'b1;
        end
        chk({tag, ":hold"}, 32'(hold_bad), 32'd0);
        chk({tag, ":q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, ":r"}, 32'(bus.remainder), 32'(er));
        chk({tag, ":dbz"}, 32'(bus.div_by_zero), 32'(ez));
        last_q = bus.quotient;
        last_r = bus.remainder;
        last_z = bus.div_by_zero;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ":valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ":ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bit stale;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst:in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst:out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst:q", 32'(bus.quotient), 32'd0);
        chk("rst:r", 32'(bus.remainder), 32'd0);
        chk("rst:dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel:in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        chk("rel:in_ready_high", 32'(bus.in_ready), 32'd1);

        // 200/7 = 28 r 4
        xact("d200_7", 8'd200, 4'd7, 0, 0);
        chk("d200_7:q_hand", 32'(last_q), 32'd28);
        chk("d200_7:r_hand", 32'(last_r), 32'd4);

        // Back-to-back 255/1 then 0/15
        xact("d255_1", 8'd255, 4'd1, 0, 0);
        first_acc = accept_cyc;
        chk("d255_1:q_hand", 32'(last_q), 32'd255);
        chk("d255_1:r_hand", 32'(last_r), 32'd0);
        xact("d0_15", 8'd0, 4'd15, 0, 0);
        chk("b2b:spacing", 32'(accept_cyc - first_acc), 32'd10);
        chk("d0_15:q_hand", 32'(last_q), 32'd0);
        chk("d0_15:r_hand", 32'(last_r), 32'd0);

        // 173/0 divide-by-zero
        xact("d173_0", 8'd173, 4'd0, 0, 0);
        chk("d173_0:q_hand", 32'(last_q), 32'd255);
        chk("d173_0:r_hand", 32'(last_r), 32'd13);
        chk("d173_0:z_hand", 32'(last_z), 32'd1);

        // 9/12 with 6 cycles of backpressure
        xact("d9_12", 8'd9, 4'd12, 0, 6);
        chk("d9_12:q_hand", 32'(last_q), 32'd0);
        chk("d9_12:r_hand", 32'(last_r), 32'd9);

        // Asynchronous reset three edges into 100/3
        bus.in_valid = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort:out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort:q", 32'(bus.quotient), 32'd0);
        chk("abort:r", 32'(bus.remainder), 32'd0);
        chk("abort:dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        chk("abort:no_stale", 32'(stale), 32'd0);
        xact("d100_3", 8'd100, 4'd3, 0, 0);
        chk("d100_3:q_hand", 32'(last_q), 32'd33);
        chk("d100_3:r_hand", 32'(last_r), 32'd1);

        // Exhaustive sweep with random idle gaps and output stalls
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                xact("sweep", 8'(a), 4'(b), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
